// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b line-code tables and helpers for the lane encoders.
// Tables hold the forms used when the entering running disparity is negative.
package enc8b10b_pkg;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [9:0] K28_5_RDN = 10'h0FA;
  localparam logic [9:0] K28_5_RDP = 10'h305;

  // abcdei for D.0 .. D.31
  localparam logic [0:31][5:0] TBL_5B6B = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
  };

  localparam logic [5:0] K28_6B = 6'b001111;

  // fghj for D.x.0 .. D.x.7 (primary forms)
  localparam logic [0:7][3:0] TBL_3B4B = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
  };

  // fghj for K.x.0 .. K.x.7; every K sub-block is complemented at RD+
  localparam logic [0:7][3:0] TBL_K_3B4B = '{
    4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111
  };

  localparam logic [3:0] ALT_3B4B = 4'b0111;

  localparam int N_LEGAL_K = 12;
  localparam logic [0:N_LEGAL_K-1][7:0] LEGAL_K = '{
    8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
    8'hF7, 8'hFB, 8'hFD, 8'hFE
  };

  function automatic logic is_legal_k(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_LEGAL_K; i++) begin
      if (LEGAL_K[i] == b) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic balanced6(input logic [5:0] c);
    return $countones(c) == 3;
  endfunction

  function automatic logic balanced4(input logic [3:0] c);
    return $countones(c) == 2;
  endfunction

endpackage

// File: rtl/enc_8b10b_byte.sv
// Combinational single-byte 8b/10b encoder with running-disparity in/out.
// Illegal K requests fall back to the D encoding of the same byte.
module enc_8b10b_byte
  import enc8b10b_pkg::*;
(
  input  logic [7:0] data,
  input  logic       k,
  input  logic       rd_in,
  output logic [9:0] code,
  output logic       rd_out,
  output logic       k_err
);

  logic [4:0] x;
  logic [2:0] y;
  logic       k_ok;
  logic       k28;
  logic [5:0] base6;
  logic [5:0] code6;
  logic       flip6;
  logic       rd_mid;
  logic       alt7;
  logic [3:0] base4;
  logic [3:0] code4;
  logic       flip4;

  assign x     = data[4:0];
  assign y     = data[7:5];
  assign k_ok  = k && is_legal_k(data);
  assign k_err = k && !k_ok;
  assign k28   = k_ok && (x == 5'd28);

  // D.7 is balanced yet still has distinct RD-/RD+ forms
  assign base6  = k28 ? K28_6B : TBL_5B6B[x];
  assign flip6  = !balanced6(base6) || (x == 5'd7);
  assign code6  = (rd_in && flip6) ? ~base6 : base6;
  assign rd_mid = balanced6(base6) ? rd_in : !rd_in;

  // A7 avoids a run of five equal bits across the e/i-f/g boundary
  assign alt7 = (y == 3'd7) && !k_ok &&
                ((!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                 ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));

  assign base4  = k_ok ? TBL_K_3B4B[y] : (alt7 ? ALT_3B4B : TBL_3B4B[y]);
  assign flip4  = k_ok || !balanced4(base4) || (y == 3'd3);
  assign code4  = (rd_mid && flip4) ? ~base4 : base4;
  assign rd_out = balanced4(base4) ? rd_mid : !rd_mid;

  assign code = {code6, code4};

endmodule

// File: rtl/enc_8b10b_lanes.sv
// Multi-lane 8b/10b encoder: RD chained lane 0 -> LANES-1 within a beat,
// one registered valid/ready output stage, RD carried between beats.
module enc_8b10b_lanes
  import enc8b10b_pkg::*;
#(
  parameter int LANES   = 2,
  parameter bit RD_INIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*LANES-1:0]    in_data,
  input  logic [LANES-1:0]      in_k,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [10*LANES-1:0]   out_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      k_err,
  output logic                  rd
);

  logic [10*LANES-1:0] out_code_reg;
  logic [10*LANES-1:0] code_next;
  logic [LANES-1:0]    k_err_reg;
  logic [LANES-1:0]    k_err_next;
  logic                out_valid_reg;
  logic                rd_reg;
  logic [LANES:0]      rd_chain;
  logic                accept;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  assign rd_chain[0] = rd_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      enc_8b10b_byte u_enc (
        .data   (in_data[8*gi +: 8]),
        .k      (in_k[gi]),
        .rd_in  (rd_chain[gi]),
        .code   (code_next[10*gi +: 10]),
        .rd_out (rd_chain[gi+1]),
        .k_err  (k_err_next[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_code_reg  <= '0;
      k_err_reg     <= '0;
      rd_reg        <= RD_INIT;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_code_reg  <= code_next;
      k_err_reg     <= k_err_next;
      rd_reg        <= rd_chain[LANES];
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_code  = out_code_reg;
  assign out_valid = out_valid_reg;
  assign k_err     = k_err_reg;
  assign rd        = rd_reg;

endmodule
